// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between mem_access_ctrl and the data memory port.
//   mem_address     word-aligned request address
//   mem_read        read strobe
//   mem_write       write strobe
//   mem_byteenable  lane enables, bit3 = bits[31:24] (big-endian lane 0)
//   mem_writedata   lane-replicated store data
//   mem_readdata    read data, valid when mem_waitrequest is low
//   mem_waitrequest stall; the master holds its request while high
// master: the access controller; slave: the memory.
interface mem_access_ctrl_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences every data-memory access of the multicycle core.
// A start pulse in IDLE latches the effective address, op, store data and
// the old rt value; the controller then issues one word-aligned request with
// byte enables, holds it through wait states and returns the extended (or
// merged) load result.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle request, accepted only in IDLE
//   op                0 LB,1 LBU,2 LH,3 LHU,4 LW,5 LWL,6 LWR,8 SB,9 SH,A SW
//   addr              effective address, sampled with start
//   store_data        rt value for stores, sampled with start
//   rt_old            rt value for LWL/LWR merge, sampled with start
//   bus               data-memory bus (mem_access_ctrl_if.master)
//   busy              high while the request is on the bus
//   done              one-cycle completion pulse
//   addr_err          valid with done: misaligned address or illegal op
//   load_result       valid from done, held until the next load completes
//
// Configuration macro: UNALIGNED_LWLR_EN enables LWL/LWR. Without it ops 5
// and 6 are illegal and rt_old is ignored.
//
// Lanes are big-endian: addr[1:0]=0 is bits[31:24], 3 is bits[7:0].

`ifdef UNALIGNED_LWLR_EN
// One byte lane of the LWL/LWR merge: keep the old rt byte or take the
// shifted memory byte.
module mem_access_lane (
  input  logic [7:0] sh_b,
  input  logic [7:0] rt_b,
  input  logic       keep,
  output logic [7:0] res_b
);
  assign res_b = keep ? rt_b : sh_b;
endmodule
`endif

module mem_access_ctrl (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [31:0]         addr,
  input  logic [31:0]         store_data,
  input  logic [31:0]         rt_old,
  mem_access_ctrl_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                addr_err,
  output logic [31:0]         load_result
);

  localparam int NUM_LANES = 4;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LBU = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LHU = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_LWL = 4'h5;
  localparam logic [3:0] OP_LWR = 4'h6;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  op;
    logic [31:0] sd;
`ifdef UNALIGNED_LWLR_EN
    logic [31:0] rt;
`endif
  } req_t;

  state_t      state, nxt;
  req_t        req_q;
  logic        req_bad;
  logic [1:0]  lsb;
  logic        is_st;
  logic [31:0] rd;
  logic [7:0]  byte_b;
  logic [15:0] half_h;
  logic [31:0] ld_val;
  logic [3:0]  be;
  logic [31:0] wd;

  assign lsb   = req_q.addr[1:0];
  assign is_st = req_q.op[3];
  assign rd    = bus.mem_readdata;

  // Illegal op or misalignment is decided on the live inputs so a bad
  // request goes straight to ERR without touching the bus.
  always_comb begin
    req_bad = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB: req_bad = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_bad = addr[0];
      OP_LW, OP_SW:         req_bad = |addr[1:0];
`ifdef UNALIGNED_LWLR_EN
      OP_LWL, OP_LWR:       req_bad = 1'b0;
`endif
      default:              req_bad = 1'b1;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = req_bad ? ERR : ACCESS;
      ACCESS:  if (!bus.mem_waitrequest) nxt = DONE;
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Bus outputs come only from latched request state, so they stay
  // stable for the whole ACCESS phase and read zero elsewhere.
  always_comb begin
    bus.mem_address    = 32'h0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_byteenable = 4'h0;
    bus.mem_writedata  = 32'h0;
    busy               = 1'b0;
    done               = 1'b0;
    addr_err           = 1'b0;
    case (state)
      ACCESS: begin
        bus.mem_address    = {req_q.addr[31:2], 2'b00};
        bus.mem_read       = ~is_st;
        bus.mem_write      = is_st;
        bus.mem_byteenable = be;
        bus.mem_writedata  = wd;
        busy               = 1'b1;
      end
      DONE: done = 1'b1;
      ERR: begin
        done     = 1'b1;
        addr_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte enables and store-data lane replication.
  always_comb begin
    be = 4'h0;
    wd = 32'h0;
    case (req_q.op)
      OP_LB, OP_LBU: be = 4'b1000 >> lsb;
      OP_SB: begin
        be = 4'b1000 >> lsb;
        wd = {4{req_q.sd[7:0]}};
      end
      OP_LH, OP_LHU: be = lsb[1] ? 4'b0011 : 4'b1100;
      OP_SH: begin
        be = lsb[1] ? 4'b0011 : 4'b1100;
        wd = {2{req_q.sd[15:0]}};
      end
      OP_LW: be = 4'b1111;
      OP_SW: begin
        be = 4'b1111;
        wd = req_q.sd;
      end
      OP_LWL: be = 4'b1111 >> lsb;
      OP_LWR: be = ~(4'b0111 >> lsb);
      default: ;
    endcase
  end

  always_comb begin
    byte_b = rd[31:24];
    case (lsb)
      2'd0: byte_b = rd[31:24];
      2'd1: byte_b = rd[23:16];
      2'd2: byte_b = rd[15:8];
      2'd3: byte_b = rd[7:0];
      default: ;
    endcase
  end

  assign half_h = lsb[1] ? rd[15:0] : rd[31:16];

`ifdef UNALIGNED_LWLR_EN
  // LWL k: memory word shifted up by k bytes, rt keeps its low k bytes.
  // LWR k: memory word shifted down by 3-k bytes, rt keeps lanes above k.
  logic [NUM_LANES-1:0][7:0] sh_lanes, rt_lanes, mg_lanes;
  logic [NUM_LANES-1:0]      keep;
  logic                      is_lwl;

  assign is_lwl   = (req_q.op == OP_LWL);
  assign sh_lanes = is_lwl ? (rd << {lsb, 3'b000}) : (rd >> {~lsb, 3'b000});
  assign rt_lanes = req_q.rt;
  assign keep     = is_lwl ? ~(4'b1111 << lsb) : (4'b1110 << lsb);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_lane u_lane (
      .sh_b  (sh_lanes[g]),
      .rt_b  (rt_lanes[g]),
      .keep  (keep[g]),
      .res_b (mg_lanes[g])
    );
  end
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
`endif

  always_comb begin
    ld_val = load_result;
    case (req_q.op)
      OP_LB:  ld_val = {{24{byte_b[7]}}, byte_b};
      OP_LBU: ld_val = {24'h0, byte_b};
      OP_LH:  ld_val = {{16{half_h[15]}}, half_h};
      OP_LHU: ld_val = {16'h0, half_h};
      OP_LW:  ld_val = rd;
`ifdef UNALIGNED_LWLR_EN
      OP_LWL, OP_LWR: ld_val = mg_lanes;
`endif
      default: ;
    endcase
  end

  // Request latch and load-result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q       <= '0;
      load_result <= 32'h0;
    end else begin
      if (state == IDLE && start) begin
        req_q.addr <= addr;
        req_q.op   <= op;
        req_q.sd   <= store_data;
`ifdef UNALIGNED_LWLR_EN
        req_q.rt   <= rt_old;
`endif
      end
      if (state == ACCESS && !bus.mem_waitrequest && !is_st)
        load_result <= ld_val;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expected values.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr, store_data, rt_old;
  logic        busy, done, addr_err;
  logic [31:0] load_result;
  logic [31:0] rdata;
  logic        wr;

  int n_chk = 0;
  int n_err = 0;

  // Observations from the last do_op call.
  int          lat;
  logic        got_err, saw_rd, saw_wr, stable;
  logic [31:0] o_addr, o_wd;
  logic [3:0]  o_be;

  mem_access_ctrl_if bus ();
  assign bus.mem_readdata    = rdata;
  assign bus.mem_waitrequest = wr;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .addr       (addr),
    .store_data (store_data),
    .rt_old     (rt_old),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .addr_err   (addr_err),
    .load_result(load_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, stall nw ACCESS cycles, return when done is seen,
  // then step one more cycle so the controller is back in IDLE.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rt, input int nw, input logic [31:0] rdv);
    int n, k;
    logic got_done;
    start = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
    rdata = rdv; wr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; k = 0; got_done = 1'b0;
    saw_rd = 1'b0; saw_wr = 1'b0; stable = 1'b1; got_err = 1'b0;
    o_addr = '0; o_wd = '0; o_be = '0;
    while (!got_done && n <= 60) begin
      if (busy) begin
        k++;
        if (k == 1) begin
          o_addr = bus.mem_address; o_be = bus.mem_byteenable; o_wd = bus.mem_writedata;
        end else if (o_addr !== bus.mem_address || o_be !== bus.mem_byteenable ||
                     o_wd !== bus.mem_writedata)
          stable = 1'b0;
        saw_rd |= bus.mem_read;
        saw_wr |= bus.mem_write;
        wr = (k <= nw);
      end
      if (done) begin
        got_done = 1'b1;
        got_err  = addr_err;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got_done) chk("timeout", 32'(n), 32'd0);
    lat = n;
    wr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; store_data = '0; rt_old = '0;
    rdata = '0; wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(addr_err), 0);
    chk("rst_rd",   32'(bus.mem_read), 0);
    chk("rst_wr",   32'(bus.mem_write), 0);
    chk("rst_be",   32'(bus.mem_byteenable), 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_wd",   bus.mem_writedata, 0);
    chk("rst_lr",   load_result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW aligned, no wait
    do_op(4'h4, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 2);
    chk("lw_err", 32'(got_err), 0);
    chk("lw_addr", o_addr, 32'h100);
    chk("lw_be", 32'(o_be), 32'hF);
    chk("lw_rd", 32'(saw_rd), 1);
    chk("lw_wr", 32'(saw_wr), 0);
    chk("lw_lr", load_result, 32'hDEADBEEF);

    // LB lane 3 with 3 wait states
    do_op(4'h0, 32'h103, 0, 0, 3, 32'h000000F0);
    chk("lb_lat", 32'(lat), 5);
    chk("lb_be", 32'(o_be), 32'h1);
    chk("lb_addr", o_addr, 32'h100);
    chk("lb_stable", 32'(stable), 1);
    chk("lb_lr", load_result, 32'hFFFFFFF0);

    do_op(4'h1, 32'h103, 0, 0, 3, 32'h000000F0);
    chk("lbu_lat", 32'(lat), 5);
    chk("lbu_lr", load_result, 32'h000000F0);

    // SH lower half
    do_op(4'h9, 32'h202, 32'h1234ABCD, 0, 0, 32'h0);
    chk("sh_lat", 32'(lat), 2);
    chk("sh_wr", 32'(saw_wr), 1);
    chk("sh_rd", 32'(saw_rd), 0);
    chk("sh_be", 32'(o_be), 32'h3);
    chk("sh_wd", o_wd, 32'hABCDABCD);
    chk("sh_addr", o_addr, 32'h200);
    chk("sh_lr", load_result, 32'h000000F0);

    // Misaligned LW and illegal op
    do_op(4'h4, 32'h102, 0, 0, 0, 32'h55555555);
    chk("lwmis_lat", 32'(lat), 1);
    chk("lwmis_err", 32'(got_err), 1);
    chk("lwmis_rd", 32'(saw_rd), 0);
    chk("lwmis_lr", load_result, 32'h000000F0);

    do_op(4'h7, 32'h100, 0, 0, 0, 32'h55555555);
    chk("op7_lat", 32'(lat), 1);
    chk("op7_err", 32'(got_err), 1);
    chk("op7_rd", 32'(saw_rd | saw_wr), 0);

    do_op(4'h2, 32'h101, 0, 0, 0, 32'h55555555);
    chk("lhmis_err", 32'(got_err), 1);
    chk("lhmis_lat", 32'(lat), 1);

    // LH / LHU halves
    do_op(4'h2, 32'h102, 0, 0, 0, 32'h12348001);
    chk("lh_be", 32'(o_be), 32'h3);
    chk("lh_lr", load_result, 32'hFFFF8001);
    do_op(4'h3, 32'h100, 0, 0, 1, 32'h80011234);
    chk("lhu_be", 32'(o_be), 32'hC);
    chk("lhu_lat", 32'(lat), 3);
    chk("lhu_lr", load_result, 32'h00008001);

    // SB lane 1, SW
    do_op(4'h8, 32'h101, 32'h00000055, 0, 0, 32'h0);
    chk("sb_be", 32'(o_be), 32'h4);
    chk("sb_wd", o_wd, 32'h55555555);
    do_op(4'hA, 32'h104, 32'hCAFEF00D, 0, 2, 32'h0);
    chk("sw_be", 32'(o_be), 32'hF);
    chk("sw_wd", o_wd, 32'hCAFEF00D);
    chk("sw_addr", o_addr, 32'h104);
    chk("sw_stable", 32'(stable), 1);
    chk("sw_lr", load_result, 32'h00008001);

    // LWL / LWR
    do_op(4'h5, 32'h101, 0, 32'hAABBCCDD, 0, 32'h11223344);
`ifdef UNALIGNED_LWLR_EN
    chk("lwl_err", 32'(got_err), 0);
    chk("lwl_be", 32'(o_be), 32'h7);
    chk("lwl_lr", load_result, 32'h223344DD);
    do_op(4'h6, 32'h102, 0, 32'hAABBCCDD, 0, 32'h11223344);
    chk("lwr_err", 32'(got_err), 0);
    chk("lwr_be", 32'(o_be), 32'hE);
    chk("lwr_lr", load_result, 32'hAA112233);
`else
    chk("lwl_err", 32'(got_err), 1);
    chk("lwl_lat", 32'(lat), 1);
    chk("lwl_rd", 32'(saw_rd), 0);
    do_op(4'h6, 32'h102, 0, 32'hAABBCCDD, 0, 32'h11223344);
    chk("lwr_err", 32'(got_err), 1);
`endif

    // Reset during a waitrequest stall
    start = 1'b1; op = 4'h4; addr = 32'h200; rdata = 32'h12345678; wr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("stall_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("stall_rd", 32'(bus.mem_read), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstac_rd", 32'(bus.mem_read), 0);
    chk("rstac_busy", 32'(busy), 0);
    chk("rstac_done", 32'(done), 0);
    rst_n = 1'b1; wr = 1'b0;
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done |= done | busy;
    end
    chk("rstac_quiet", 32'(seen_done), 0);
    do_op(4'h4, 32'h300, 0, 0, 1, 32'h0BADF00D);
    chk("post_lat", 32'(lat), 3);
    chk("post_err", 32'(got_err), 0);
    chk("post_lr", load_result, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences every data-memory access of the multicycle MIPS core. On a start pulse it captures the ALU-computed effective address and its two LSBs, drives a word-aligned request with byte enables on the memory bus, holds it through wait states, then returns a sign- or zero-extended (or merged) load result. It sits between the main control FSM, the ALU output and the data-memory port, and replaces ad-hoc use of the stored address LSBs for lane selection.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, A SW; others illegal
- addr  in  32  effective address (ALU out), sampled with start
- store_data  in  32  rt value for stores, sampled with start
- rt_old  in  32  current rt value for LWL/LWR merge, sampled with start
- mem_address  out  32  {addr[31:2],2'b00}
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_byteenable  out  4  lane enables, bit3 = bits[31:24]
- mem_writedata  out  32  lane-replicated store data
- mem_readdata  in  32  read data, valid when waitrequest low
- mem_waitrequest  in  1  stall; strobes and outputs held while high
- busy  out  1  high in ACCESS
- done  out  1  one-cycle completion pulse
- addr_err  out  1  valid with done; misaligned or illegal op
- load_result  out  32  valid from done, held until next accepted start

## Operation
- Big-endian lanes: addr[1:0]=0 selects bits[31:24], 3 selects bits[7:0].
- States: IDLE, ACCESS, DONE, ERR.
- IDLE + start: illegal op, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 -> ERR; else -> ACCESS. Latches addr, op, store_data, rt_old.
- ACCESS: strobe asserted; waitrequest=1 stay; waitrequest=0 -> DONE, reads capture mem_readdata that cycle.
- DONE: done=1, addr_err=0 -> IDLE. ERR: done=1, addr_err=1, no strobe ever issued, load_result unchanged -> IDLE.
- Byte enables: byte ops 1000>>lsb; half ops lsb0 1100, lsb2 0011; word 1111; LWL 1111>>lsb; LWR 1000,1100,1110,1111 for lsb 0..3.
- Store data: SB {4{sd[7:0]}}, SH {2{sd[15:0]}}, SW sd.
- Loads: selected lane right-justified; LB/LH sign-extend, LBU/LHU zero-extend.
- LWL lsb k: memory bytes k..3 into result upper bytes, rt_old lower 8k bits kept. LWR lsb k: memory bytes 0..k into result lower bytes, rt_old upper bits kept.
- Stores leave load_result unchanged.

## Timing
- Reset: state IDLE; mem_read, mem_write, busy, done, addr_err = 0; mem_byteenable, mem_address, mem_writedata, load_result = 0.
- Minimum latency start -> done: 2 cycles (ACCESS 1 cycle, DONE next). Each waitrequest cycle adds one.
- Error latency start -> done: 1 cycle.
- start while not IDLE ignored; start in DONE/ERR cycle ignored (accepted next cycle).
- mem_address, byteenable, writedata, strobe stable through all of ACCESS.
- rst_n low in ACCESS: strobes low next edge, no done pulse.

## Configuration
- UNALIGNED_LWLR_EN defined: LWL/LWR supported as above, never misaligned.
- Undefined: ops 5 and 6 are illegal -> ERR with addr_err=1; merge logic and rt_old unused.

## Test plan
- LW addr=0x100, readdata 0xDEADBEEF, no wait -> mem_address 0x100, be 1111, done at start+2, load_result 0xDEADBEEF.
- LB addr=0x103, readdata 0x000000F0, 3 wait cycles -> be 0001, done at start+5, load_result 0xFFFFFFF0; LBU same -> 0x000000F0.
- SH addr=0x202, store_data 0x1234ABCD -> mem_write, be 0011, writedata 0xABCDABCD, load_result unchanged.
- LW addr=0x102 -> done+addr_err at start+1, mem_read never asserted; op 7 same.
- LWL addr=0x101, readdata 0x11223344, rt_old 0xAABBCCDD -> 0x223344DD (macro on); macro off -> addr_err.
- rst_n low during waitrequest stall -> next cycle strobes 0, busy 0, no done; new start then completes normally.
